wf_ram_reader: RTL and testbench
================================

# wf_ram_reader

Waveform DPBRAM read-back engine: the read-side counterpart of the WF write path. Software loads waveform samples into the DPBRAM through the WF writer. This block then walks the RAM's second port sequentially from address 0 and presents each 16-bit sample on a valid/ready stream for the downstream DAC/reference logic. It supports one-shot and looped playback, plus a delivered-sample counter that is read back over AXI.

## Interface
Parameters:
- ADDR_WIDTH, 10, DPBRAM address width (depth = 2^ADDR_WIDTH)
- DATA_WIDTH, 16, sample width

Ports:
- i_clk  in  1  system clock; the only clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  single-cycle start pulse
- i_stop  in  1  single-cycle abort pulse
- i_loop  in  1  1 = restart from address 0 after the last sample; latched at start
- i_data_num  in  ADDR_WIDTH+1  number of samples to play (1..2^ADDR_WIDTH); latched at start
- o_ram_addr  out  ADDR_WIDTH  DPBRAM read address (registered)
- o_ram_ce  out  1  DPBRAM enable (registered)
- o_ram_we  out  1  DPBRAM write enable; constant 0
- i_ram_dout  in  DATA_WIDTH  DPBRAM read data; valid 1 cycle after the ce cycle
- o_data  out  DATA_WIDTH  output sample
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts o_data
- o_busy  out  1  engine not IDLE
- o_done  out  1  1-cycle pulse on completion of a one-shot run
- o_wrap  out  1  1-cycle pulse on each loop restart
- o_err  out  1  1-cycle pulse when a start is rejected
- o_read_cnt  out  32  samples delivered since the last accepted start

## Operation
- FSM states: IDLE, RD, LAT, OUT.
- IDLE:
  - On i_start with 1 ≤ i_data_num ≤ 2^ADDR_WIDTH: latch num and loop, clear idx and o_read_cnt, go to RD with o_ram_addr=0.
  - On i_start with i_data_num outside that range: pulse o_err and stay in IDLE.
- RD: o_ram_ce=1 for exactly this cycle at o_ram_addr=idx. Next state is LAT.
- LAT: o_ram_ce=0. At the end of the cycle, capture i_ram_dout into o_data. Next state is OUT.
- OUT: o_valid=1 and o_data is held stable until o_valid&i_ready. On handshake, o_read_cnt increments (wraps at 2^32), then:
  - idx+1 < num: idx += 1, go to RD.
  - idx+1 == num and loop=1: idx=0, o_ram_addr=0, pulse o_wrap, go to RD.
  - idx+1 == num and loop=0: pulse o_done, go to IDLE.
- i_stop in any non-IDLE state: go to IDLE on the next edge. o_valid and o_ram_ce drop, with no o_done. o_read_cnt and o_data hold their values.
- i_start while busy is ignored.
- i_start and i_stop in the same cycle in IDLE: stop wins; no start, no o_err.
- i_data_num, i_loop, and i_start changes mid-run have no effect.
- o_busy=1 in RD/LAT/OUT.
- Reset values (all outputs): o_ram_addr=0, o_ram_ce=0, o_data=0, o_valid=0, o_busy=0, o_done=0, o_wrap=0, o_err=0, o_read_cnt=0; state IDLE.
- i_rst mid-run aborts immediately to the reset values; no pulses are generated.

## Timing
- All outputs are registered.
- Start accepted at edge E: RD is the cycle after E (o_ram_ce=1, addr=0). LAT follows, then the first o_valid=1 appears in the 3rd cycle after E.
- Per-sample cost is 3 cycles + the number of cycles i_ready is low in OUT. Max throughput is 1 sample / 3 cycles.
- Handshake in the last OUT cycle:
  - one-shot: o_done=1 and o_busy=0 in the next cycle.
  - loop: o_wrap=1 coincides with RD at addr 0.
- o_err asserts in the cycle after the rejected i_start.
- i_stop at edge E: o_busy=0 in the cycle after E.

## Test plan
- RAM preloaded with addr k → 0x1000+k. Start with num=4, loop=0, i_ready=1 → o_data sequence 0x1000..0x1003, each at 3-cycle spacing; o_done 1 cycle after the last handshake; o_read_cnt=4.
- num=2, loop=1, run 7 handshakes → data 0x1000,0x1001 repeating; 3 o_wrap pulses; o_read_cnt=7.
- num=3, i_ready held low for 5 cycles on the 2nd sample → o_data=0x1001 stable and o_valid=1 throughout; no address advance.
- num=0 and num=1025 → o_err pulse, o_busy stays 0. num=1024 → last o_ram_addr=1023, then o_done.
- i_stop in LAT, and separately i_rst in OUT → IDLE next cycle, o_valid=0, no o_done. A subsequent start replays from addr 0 with o_read_cnt cleared.
- i_start pulsed during a run → ignored (sequence unchanged). i_start+i_stop together in IDLE → no start, no o_err.

Source files
------------

// File: rtl/wf_ram_reader.sv
// Waveform DPBRAM read-back engine: walks the RAM's read port from address 0
// and streams each sample over valid/ready, with one-shot or looped playback.
module wf_ram_reader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_loop,
  input  logic [ADDR_WIDTH:0]   i_data_num,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_ce,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_dout,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_wrap,
  output logic                  o_err,
  output logic [31:0]           o_read_cnt
);

  localparam int unsigned NUM_W = ADDR_WIDTH + 1;
  localparam logic [NUM_W-1:0] MAX_NUM = NUM_W'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RD, LAT, OUT} state_t;

  state_t                state_q;
  logic [NUM_W-1:0]      num_q;
  logic                  loop_q;
  logic [ADDR_WIDTH-1:0] idx_q;

  logic [NUM_W-1:0] idx_inc_c;
  logic             start_ok_c;

  assign idx_inc_c  = NUM_W'(idx_q) + NUM_W'(1);
  assign start_ok_c = (i_data_num != '0) && (i_data_num <= MAX_NUM);
  assign o_ram_we   = 1'b0;

  // Playback FSM; pulses default low and are raised for a single cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      num_q      <= '0;
      loop_q     <= 1'b0;
      idx_q      <= '0;
      o_ram_addr <= '0;
      o_ram_ce   <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_wrap     <= 1'b0;
      o_err      <= 1'b0;
      o_read_cnt <= '0;
    end else begin
      o_done <= 1'b0;
      o_wrap <= 1'b0;
      o_err  <= 1'b0;
      if (state_q != IDLE && i_stop) begin
        // Abort keeps the sample counter, last data and last address.
        state_q  <= IDLE;
        o_ram_ce <= 1'b0;
        o_valid  <= 1'b0;
        o_busy   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (i_start && !i_stop) begin
              if (start_ok_c) begin
                num_q      <= i_data_num;
                loop_q     <= i_loop;
                idx_q      <= '0;
                o_read_cnt <= '0;
                o_ram_addr <= '0;
                o_ram_ce   <= 1'b1;
                o_busy     <= 1'b1;
                state_q    <= RD;
              end else begin
                o_err <= 1'b1;
              end
            end
          end
          RD: begin
            o_ram_ce <= 1'b0;
            state_q  <= LAT;
          end
          LAT: begin
            o_data  <= i_ram_dout;
            o_valid <= 1'b1;
            state_q <= OUT;
          end
          OUT: begin
            if (i_ready) begin
              o_valid    <= 1'b0;
              o_read_cnt <= o_read_cnt + 32'd1;
              if (idx_inc_c < num_q) begin
                idx_q      <= idx_q + ADDR_WIDTH'(1);
                o_ram_addr <= idx_q + ADDR_WIDTH'(1);
                o_ram_ce   <= 1'b1;
                state_q    <= RD;
              end else if (loop_q) begin
                idx_q      <= '0;
                o_ram_addr <= '0;
                o_ram_ce   <= 1'b1;
                o_wrap     <= 1'b1;
                state_q    <= RD;
              end else begin
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wf_ram_reader.sv
// Self-checking bench for wf_ram_reader: directed test-plan scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_wf_ram_reader;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, stop, loop_en, ready;
  logic [AW:0]   num;
  logic [AW-1:0] ram_addr;
  logic          ram_ce, ram_we;
  logic [DW-1:0] ram_dout, data;
  logic          valid, busy, done, wrap, err;
  logic [31:0]   read_cnt;

  always #5 clk = ~clk;

  wf_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_loop(loop_en),
    .i_data_num(num), .o_ram_addr(ram_addr), .o_ram_ce(ram_ce), .o_ram_we(ram_we),
    .i_ram_dout(ram_dout), .o_data(data), .o_valid(valid), .i_ready(ready),
    .o_busy(busy), .o_done(done), .o_wrap(wrap), .o_err(err), .o_read_cnt(read_cnt)
  );

  // DPBRAM read port: one-cycle registered read
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) if (ram_ce) ram_dout <= ram[ram_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Observed stream
  logic [DW-1:0] hs_q[$];
  int            hs_count = 0;
  int            wrap_count = 0;
  logic [AW-1:0] last_ce_addr = '0;

  // Behavioural model: sample fetch = ce cycle, latency cycle, then offer
  bit          m_busy = 0, m_loop = 0, m_done = 0, m_wrap = 0, m_err = 0;
  int          m_phase = 0, m_num = 0, m_idx = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic [31:0]   m_cnt = '0;

  always @(posedge clk) begin
    if (valid === 1'b1 && ready && !rst && !stop) begin
      hs_q.push_back(data);
      hs_count++;
    end
    if (wrap === 1'b1) wrap_count++;
    if (ram_ce === 1'b1) last_ce_addr = ram_addr;

    m_done = 0; m_wrap = 0; m_err = 0;
    if (rst) begin
      m_busy = 0; m_phase = 0; m_addr = '0; m_data = '0; m_cnt = '0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        if (int'(num) >= 1 && int'(num) <= (1 << AW)) begin
          m_num = int'(num); m_loop = loop_en; m_idx = 0; m_cnt = '0;
          m_addr = '0; m_busy = 1; m_phase = 0;
        end else m_err = 1;
      end
    end else if (stop) begin
      m_busy = 0;
    end else if (m_phase < 2) begin
      m_phase++;
      if (m_phase == 2) m_data = ram[m_idx];
    end else if (ready) begin
      m_cnt++;
      if (m_idx + 1 < m_num) begin
        m_idx++; m_addr = AW'(m_idx); m_phase = 0;
      end else if (m_loop) begin
        m_idx = 0; m_addr = '0; m_wrap = 1; m_phase = 0;
      end else begin
        m_done = 1; m_busy = 0;
      end
    end

    #4;
    chk("cyc_busy",  32'(busy),     32'(m_busy));
    chk("cyc_ce",    32'(ram_ce),   32'(m_busy && m_phase == 0));
    chk("cyc_valid", 32'(valid),    32'(m_busy && m_phase == 2));
    chk("cyc_addr",  32'(ram_addr), 32'(m_addr));
    chk("cyc_data",  32'(data),     32'(m_data));
    chk("cyc_cnt",   read_cnt,      m_cnt);
    chk("cyc_done",  32'(done),     32'(m_done));
    chk("cyc_wrap",  32'(wrap),     32'(m_wrap));
    chk("cyc_err",   32'(err),      32'(m_err));
    chk("cyc_we",    32'(ram_we),   32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input bit lp);
    start = 1'b1; num = (AW+1)'(n); loop_en = lp;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      if (!busy) break;
      tick();
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_hs(input int target, input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      if (hs_count >= target) break;
      tick();
    end
    chk(name, 32'(hs_count >= target), 32'd1);
  endtask

  int base, wbase;

  initial begin
    for (int k = 0; k < (1 << AW); k++) ram[k] = 16'h1000 + 16'(k);
    rst = 1; start = 0; stop = 0; loop_en = 0; num = '0; ready = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", read_cnt, 32'd0);
    chk("rst_data", 32'(data), 32'd0);

    // One-shot, 4 samples
    base = hs_count;
    do_start(4, 0);
    chk("t1_ce_first", 32'(ram_ce), 32'd1);
    chk("t1_addr_first", 32'(ram_addr), 32'd0);
    tick(); tick();
    chk("t1_valid_3rd", 32'(valid), 32'd1);
    wait_idle(50, "t1_timeout");
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hs", 32'(hs_count - base), 32'd4);
    for (int j = 0; j < 4; j++) chk("t1_seq", 32'(hs_q[base+j]), 32'h1000 + 32'(j));
    chk("t1_cnt", read_cnt, 32'd4);

    // Looped, 2 samples, 7 handshakes
    base = hs_count; wbase = wrap_count;
    do_start(2, 1);
    wait_hs(base + 7, 200, "t2_timeout");
    stop = 1; tick(); stop = 0;
    chk("t2_busy", 32'(busy), 32'd0);
    chk("t2_cnt", read_cnt, 32'd7);
    chk("t2_wraps", 32'(wrap_count - wbase), 32'd3);
    for (int j = 0; j < 7; j++) chk("t2_seq", 32'(hs_q[base+j]), 32'h1000 + 32'(j % 2));

    // Back-pressure on 2nd sample
    base = hs_count;
    do_start(3, 0);
    wait_hs(base + 1, 50, "t3_timeout");
    ready = 0;
    for (int i = 0; i < 10 && !valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", 32'(data), 32'h1001);
      chk("t3_hold_valid", 32'(valid), 32'd1);
      chk("t3_hold_addr", 32'(ram_addr), 32'd1);
      tick();
    end
    ready = 1;
    wait_idle(50, "t3_idle_timeout");
    chk("t3_cnt", read_cnt, 32'd3);

    // Range boundaries
    do_start(0, 0);
    chk("t4_err0", 32'(err), 32'd1);
    chk("t4_busy0", 32'(busy), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(err), 32'd0);
    do_start(1025, 0);
    chk("t4_err1025", 32'(err), 32'd1);
    chk("t4_busy1025", 32'(busy), 32'd0);
    base = hs_count;
    do_start(1024, 0);
    wait_idle(3300, "t4_full_timeout");
    chk("t4_full_done", 32'(done), 32'd1);
    chk("t4_last_addr", 32'(last_ce_addr), 32'd1023);
    chk("t4_full_cnt", read_cnt, 32'd1024);
    chk("t4_last_data", 32'(hs_q[base+1023]), 32'h13ff);

    // Stop in LAT, reset in OUT, then replay
    do_start(4, 0);
    tick();
    stop = 1; tick(); stop = 0;
    chk("t5_stop_busy", 32'(busy), 32'd0);
    chk("t5_stop_valid", 32'(valid), 32'd0);
    chk("t5_stop_done", 32'(done), 32'd0);
    do_start(4, 0);
    chk("t5_restart_cnt", read_cnt, 32'd0);
    tick(); tick();
    chk("t5_out_valid", 32'(valid), 32'd1);
    rst = 1; tick(); rst = 0;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_valid", 32'(valid), 32'd0);
    chk("t5_rst_cnt", read_cnt, 32'd0);
    base = hs_count;
    do_start(2, 0);
    wait_idle(50, "t5_replay_timeout");
    chk("t5_replay_first", 32'(hs_q[base]), 32'h1000);
    chk("t5_replay_cnt", read_cnt, 32'd2);

    // Start mid-run ignored; start+stop in IDLE does nothing
    base = hs_count;
    do_start(3, 0);
    tick(); tick();
    start = 1; num = 11'd1; loop_en = 1; tick(); start = 0;
    wait_idle(50, "t6_timeout");
    chk("t6_hs", 32'(hs_count - base), 32'd3);
    chk("t6_last", 32'(hs_q[base+2]), 32'h1002);
    start = 1; stop = 1; num = 11'd0; tick(); start = 0; stop = 0;
    chk("t6_both_err", 32'(err), 32'd0);
    chk("t6_both_busy", 32'(busy), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 499) == 0);
      ready   = ($urandom_range(0, 9) < 7);
      loop_en = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        0:       num = 11'd0;
        1:       num = 11'($urandom_range(1025, 2047));
        default: num = 11'($urandom_range(1, 6));
      endcase
      tick();
    end
    start = 0; rst = 0; ready = 1; stop = 1; tick(); stop = 0;
    wait_idle(20, "final_idle");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
